kbd_key_state: RTL and testbench

KBD_KEY_STATE -- requirements
Module: kbd_key_state

---
 rtl/kbd_pkg.sv | 19 +
 rtl/kbd_key_state.sv | 158 +++++++++++++++
 tb/tb_kbd_key_state.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 key-state decoder: prefix FSM states and
// the scan-code constants the decoder cares about.
package kbd_pkg;

  // Prefix tracking: plain, after E0, after F0, after E0 F0.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExt    = 2'd1,
    StBrk    = 2'd2,
    StExtBrk = 2'd3
  } prefix_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_FIRE  = 8'h29;

endpackage

// File: rtl/kbd_key_state.sv
// PS/2 scan-code decoder that tracks left/right arrow and space-bar held
// state. E0/F0 prefixes are followed by a small FSM; a prefix that is not
// followed by another byte within PREFIX_TIMEOUT idle cycles is dropped.
// Optional macro KBD_DIR_RESOLVE_EN: when both arrows are held only the most
// recently pressed one is reported.
module kbd_key_state
  import kbd_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] scanCode,
  input  logic       scanValid,
  output logic       leftPress,
  output logic       rightPress,
  output logic       fireHeld,
  output logic       firePulse
);

  localparam int unsigned CntW = (PREFIX_TIMEOUT > 0) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PREFIX_TIMEOUT);

  prefix_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            left_held_q, left_held_d;
  logic            right_held_q, right_held_d;
  logic            fire_held_q, fire_held_d;
  logic            left_out_d, right_out_d, fire_pulse_d;
  logic            key_evt, key_ext, key_make;
`ifdef KBD_DIR_RESOLVE_EN
  logic            last_dir_q, last_dir_d;  // 0: left pressed last, 1: right
`endif

  // Prefix FSM and timeout counter next-state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_evt  = 1'b0;
    key_ext  = 1'b0;
    key_make = 1'b0;
    if (scanValid) begin
      cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (scanCode == SC_EXT) begin
            state_d = StExt;
          end else if (scanCode == SC_BRK) begin
            state_d = StBrk;
          end else begin
            key_evt  = 1'b1;
            key_make = 1'b1;
          end
        end
        StExt: begin
          if (scanCode == SC_BRK) begin
            state_d = StExtBrk;
          end else if (scanCode != SC_EXT) begin
            key_evt  = 1'b1;
            key_ext  = 1'b1;
            key_make = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          if (scanCode == SC_EXT) begin
            state_d = StExt;
          end else if (scanCode != SC_BRK) begin
            key_evt = 1'b1;
            state_d = StIdle;
          end
        end
        StExtBrk: begin
          // A second prefix here is malformed; abandon the sequence.
          if (scanCode != SC_EXT && scanCode != SC_BRK) begin
            key_evt = 1'b1;
            key_ext = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (cnt_q == CntMax) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Key held flags and registered output values.
  always_comb begin
    left_held_d  = left_held_q;
    right_held_d = right_held_q;
    fire_held_d  = fire_held_q;
`ifdef KBD_DIR_RESOLVE_EN
    last_dir_d   = last_dir_q;
`endif
    if (key_evt) begin
      if (key_ext && scanCode == SC_LEFT) begin
        left_held_d = key_make;
`ifdef KBD_DIR_RESOLVE_EN
        if (key_make) last_dir_d = 1'b0;
`endif
      end else if (key_ext && scanCode == SC_RIGHT) begin
        right_held_d = key_make;
`ifdef KBD_DIR_RESOLVE_EN
        if (key_make) last_dir_d = 1'b1;
`endif
      end else if (!key_ext && scanCode == SC_FIRE) begin
        fire_held_d = key_make;
      end
    end
`ifdef KBD_DIR_RESOLVE_EN
    left_out_d  = left_held_d & (~right_held_d | ~last_dir_d);
    right_out_d = right_held_d & (~left_held_d | last_dir_d);
`else
    left_out_d  = left_held_d;
    right_out_d = right_held_d;
`endif
    fire_pulse_d = fire_held_d & ~fire_held_q;
  end

  // State, flags and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      left_held_q  <= 1'b0;
      right_held_q <= 1'b0;
      fire_held_q  <= 1'b0;
`ifdef KBD_DIR_RESOLVE_EN
      last_dir_q   <= 1'b0;
`endif
      leftPress    <= 1'b0;
      rightPress   <= 1'b0;
      fireHeld     <= 1'b0;
      firePulse    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      left_held_q  <= left_held_d;
      right_held_q <= right_held_d;
      fire_held_q  <= fire_held_d;
`ifdef KBD_DIR_RESOLVE_EN
      last_dir_q   <= last_dir_d;
`endif
      leftPress    <= left_out_d;
      rightPress   <= right_out_d;
      fireHeld     <= fire_held_d;
      firePulse    <= fire_pulse_d;
    end
  end

endmodule

// File: tb/tb_kbd_key_state.sv
// Bench for kbd_key_state: directed scenarios plus a randomized byte stream
// checked against a prefix/key-set reference model. Honours KBD_DIR_RESOLVE_EN.
module tb_kbd_key_state;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] scanCode = 8'h00;
  logic       scanValid = 1'b0;
  logic       leftPress, rightPress, fireHeld, firePulse;

  int total = 0;
  int bad = 0;

  // Reference model: pending prefixes, idle cycles since last byte, key set.
  bit m_ext, m_brk, m_l, m_r, m_f, m_last, m_pulse;
  int m_idle;

  kbd_key_state #(.PREFIX_TIMEOUT(T)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .scanCode  (scanCode),
    .scanValid (scanValid),
    .leftPress (leftPress),
    .rightPress(rightPress),
    .fireHeld  (fireHeld),
    .firePulse (firePulse)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {leftPress, rightPress, fireHeld, firePulse};
  endfunction

  function automatic logic [3:0] model_out();
    bit l, r;
`ifdef KBD_DIR_RESOLVE_EN
    l = m_l && !(m_r && m_last);
    r = m_r && !(m_l && !m_last);
`else
    l = m_l;
    r = m_r;
`endif
    return {l, r, m_f, m_pulse};
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_l = 0; m_r = 0; m_f = 0; m_last = 0; m_pulse = 0;
    m_idle = 0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    bit prev_f;
    prev_f = m_f;
    if ((m_ext || m_brk) && m_idle > int'(T)) begin
      m_ext = 0;
      m_brk = 0;
    end
    if (c == 8'hE0) begin
      if (m_ext && m_brk) begin m_ext = 0; m_brk = 0; end
      else begin m_ext = 1; m_brk = 0; end
    end else if (c == 8'hF0) begin
      if (m_ext && m_brk) begin m_ext = 0; m_brk = 0; end
      else m_brk = 1;
    end else begin
      if (m_ext && c == 8'h6B) begin m_l = !m_brk; if (!m_brk) m_last = 0; end
      if (m_ext && c == 8'h74) begin m_r = !m_brk; if (!m_brk) m_last = 1; end
      if (!m_ext && c == 8'h29) m_f = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
    m_pulse = m_f && !prev_f;
    m_idle = 0;
  endtask

  // One clock cycle with an optional byte; model advanced to match.
  task automatic step(input bit v, input logic [7:0] c);
    scanValid = v;
    scanCode  = c;
    @(posedge clk);
    #1;
    scanValid = 1'b0;
    if (v) model_byte(c);
    else begin
      m_idle++;
      m_pulse = 0;
    end
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs() !== 4'b0000) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 4'b0000);
    end
    resetN = 1'b1;
    model_reset();
    send(8'h29);  // first cycle after release
    total++;
    if (obs() !== 4'b0011) begin
      bad++; $display("FAIL first_byte_after_reset got=%b exp=%b", obs(), 4'b0011);
    end
  endtask

  task automatic test_left();
    do_reset();
    send(8'hE0);
    total++;
    if (obs() !== 4'b0000) begin
      bad++; $display("FAIL left_prefix_only got=%b exp=%b", obs(), 4'b0000);
    end
    send(8'h6B);
    total++;
    if (obs() !== 4'b1000) begin
      bad++; $display("FAIL left_make got=%b exp=%b", obs(), 4'b1000);
    end
    send(8'hE0); send(8'hF0); send(8'h6B);
    total++;
    if (obs() !== 4'b0000) begin
      bad++; $display("FAIL left_break got=%b exp=%b", obs(), 4'b0000);
    end
  endtask

  task automatic test_fire();
    logic [3:0] exp_seq [5];
    logic [7:0] bytes [5];
    int pulses;
    bytes   = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29};
    exp_seq = '{4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    pulses = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(bytes[i]);
      pulses += int'(firePulse);
      total++;
      if (obs() !== exp_seq[i]) begin
        bad++; $display("FAIL fire_seq[%0d] got=%b exp=%b", i, obs(), exp_seq[i]);
      end
    end
    idle(2);
    pulses += int'(firePulse);
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL fire_pulse_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'hE0); idle(20); send(8'h6B);
    total++;
    if (obs() !== 4'b0000) begin
      bad++; $display("FAIL timeout_drop_ext got=%b exp=%b", obs(), 4'b0000);
    end
    send(8'hE0); idle(T); send(8'h6B);
    total++;
    if (obs() !== 4'b1000) begin
      bad++; $display("FAIL timeout_edge_kept got=%b exp=%b", obs(), 4'b1000);
    end
    send(8'hE0); send(8'hF0); idle(T + 1); send(8'h6B);
    total++;
    if (obs() !== 4'b1000) begin
      bad++; $display("FAIL timeout_drop_break got=%b exp=%b", obs(), 4'b1000);
    end
  endtask

  task automatic test_dir();
    logic [3:0] exp;
    do_reset();
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
`ifdef KBD_DIR_RESOLVE_EN
    exp = 4'b0100;
`else
    exp = 4'b1100;
`endif
    total++;
    if (obs() !== exp) begin
      bad++; $display("FAIL dir_both_held got=%b exp=%b", obs(), exp);
    end
    send(8'hE0); send(8'hF0); send(8'h74);
    total++;
    if (obs() !== 4'b1000) begin
      bad++; $display("FAIL dir_release_right got=%b exp=%b", obs(), 4'b1000);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0);
    resetN = 1'b0;
    #2;
    total++;
    if (obs() !== 4'b0000) begin
      bad++; $display("FAIL async_reset got=%b exp=%b", obs(), 4'b0000);
    end
    @(posedge clk);
    #1;
    resetN = 1'b1;
    model_reset();
    send(8'h6B);
    total++;
    if (obs() !== 4'b0000) begin
      bad++; $display("FAIL reset_mid_seq got=%b exp=%b", obs(), 4'b0000);
    end
    send(8'hE0); send(8'h6B);
    total++;
    if (obs() !== 4'b1000) begin
      bad++; $display("FAIL reset_fsm_idle got=%b exp=%b", obs(), 4'b1000);
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] bytes [3];
    bytes = '{8'h1C, 8'hE0, 8'h75};
    do_reset();
    send(8'hE0); send(8'h74);
    for (int i = 0; i < 3; i++) begin
      send(bytes[i]);
      total++;
      if (obs() !== 4'b0100) begin
        bad++; $display("FAIL unmapped[%0d] got=%b exp=%b", i, obs(), 4'b0100);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [10];
    logic [7:0] b;
    int r, gap;
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h29, 8'hE0, 8'hF0, 8'h1C, 8'h75, 8'h00};
    do_reset();
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 9));
      gap = (r < 6) ? 0 : (r < 8) ? int'($urandom_range(1, 4))
                                   : int'($urandom_range(T - 1, T + 3));
      for (int k = 0; k < gap; k++) begin
        step(1'b0, 8'h00);
        total++;
        if (obs() !== model_out()) begin
          bad++; $display("FAIL rand_idle[%0d] got=%b exp=%b", n, obs(), model_out());
        end
      end
      b = pool[$urandom_range(0, 9)];
      if (b == 8'h00) b = 8'($urandom);
      send(b);
      total++;
      if (obs() !== model_out()) begin
        bad++; $display("FAIL rand_byte[%0d] code=%h got=%b exp=%b", n, b, obs(), model_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_left();
    test_fire();
    test_timeout();
    test_dir();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
